// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring radix-2 integer divider implementing MIPS DIV (signed)
//   and DIVU (unsigned). One trial subtraction per clock, fixed latency of
//   WIDTH+2 cycles from the accepted start to the done pulse, including the
//   divide-by-zero case.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        request pulse, accepted only in IDLE or DONE
//   is_signed    1 = DIV (two's complement), 0 = DIVU
//   dividend     A operand, sampled with start
//   divisor      B operand, sampled with start
//   busy         high while a division is in flight (DIVIDE, FIXUP)
//   done         one-cycle pulse, results valid
//   quotient     LO result
//   remainder    HI result
//   div_by_zero  divisor was zero; valid with done and held afterwards
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIXUP,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] orig_dividend;
  logic             sign_q;
  logic             sign_r;
  logic             zero_div;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // exactly its magnitude when read as an unsigned WIDTH-bit number.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? (~dividend + ONE) : dividend;
  assign b_mag = b_neg ? (~divisor + ONE) : divisor;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor magnitude with one extra bit so the
  // top bit acts as the borrow / sign of the trial result.
  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  assign partial = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = partial - {1'b0, div_mag};

  // Negated results for the signed fix-up
  logic [WIDTH-1:0] quo_neg;
  logic [WIDTH-1:0] rem_neg;

  assign quo_neg = ~quo_reg + ONE;
  assign rem_neg = ~rem_reg + ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      div_mag       <= '0;
      orig_dividend <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      zero_div      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            quo_reg       <= a_mag;
            div_mag       <= b_mag;
            orig_dividend <= dividend;
            sign_q        <= a_neg ^ b_neg;
            sign_r        <= a_neg;
            zero_div      <= (divisor == '0);
            div_by_zero   <= 1'b0;
            rem_reg       <= '0;
            count         <= LAST_COUNT;
            busy          <= 1'b1;
            state         <= DIVIDE;
          end else begin
            state <= IDLE;
          end
        end

        DIVIDE: begin
          // A clear borrow bit means the trial fits: keep it and set the q bit
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= partial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          count <= count - CW'(1);
          if (count == '0) begin
            state <= FIXUP;
          end
        end

        FIXUP: begin
          // Divide-by-zero still spends the full latency so timing never
          // depends on operand values.
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= orig_dividend;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? quo_neg : quo_reg;
            remainder   <= sign_r ? rem_neg : rem_reg;
            div_by_zero <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed self-checking bench for seq_divider (WIDTH = 32). Expected
//   quotients/remainders are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle, then scrambles the operand inputs,
  // which must be ignored once the request has been accepted.
  task automatic apply_stimulus(input logic s, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    next_cycle();
    start     = 1'b0;
    is_signed = ~s;
    dividend  = ~a;
    divisor   = ~b;
  endtask

  // Bounded wait for done; c0 is the cycle number of the current sample point
  task automatic wait_done(input int c0, output int c_done, output int busy_bad);
    int c;
    c        = c0;
    busy_bad = 0;
    while (done !== 1'b1 && c < 200) begin
      if (busy !== 1'b1) busy_bad++;
      next_cycle();
      c++;
    end
    c_done = c;
  endtask

  task automatic run_div(input string tag, input logic s,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic ez);
    int c;
    int bb;
    apply_stimulus(s, a, b);
    wait_done(1, c, bb);
    check_output({tag, " latency"}, c, LAT);
    check_output({tag, " busy gaps"}, bb, 0);
    check_output({tag, " busy at done"}, busy, 0);
    check_output({tag, " quotient"}, quotient, eq);
    check_output({tag, " remainder"}, remainder, er);
    check_output({tag, " div_by_zero"}, div_by_zero, ez);
    next_cycle();
    check_output({tag, " done width"}, done, 0);
    check_output({tag, " quotient hold"}, quotient, eq);
    check_output({tag, " dbz hold"}, div_by_zero, ez);
  endtask

  initial begin
    int c;
    int bb;
    int done_seen;

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    next_cycle();
    next_cycle();
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset quotient", quotient, 0);
    check_output("reset remainder", remainder, 0);
    check_output("reset dbz", div_by_zero, 0);
    rst = 1'b0;
    next_cycle();

    $display("[TB] basic unsigned and signed divisions");
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("div -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_div("divu 5/max", 1'b0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);

    $display("[TB] divide by zero and recovery");
    run_div("divu x/0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_div("divu 10/3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    $display("[TB] signed overflow");
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);

    $display("[TB] handshake: start while busy, back-to-back start");
    apply_stimulus(1'b0, 32'd1000, 32'd9);
    repeat (9) next_cycle();
    is_signed = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    next_cycle();
    start     = 1'b0;
    wait_done(11, c, bb);
    check_output("busy start latency", c, LAT);
    check_output("busy start busy gaps", bb, 0);
    check_output("busy start quotient", quotient, 32'd111);
    check_output("busy start remainder", remainder, 32'd1);
    apply_stimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(1, c, bb);
    check_output("back-to-back latency", c + LAT, 2 * LAT);
    check_output("back-to-back busy gaps", bb, 0);
    check_output("back-to-back quotient", quotient, 32'hFFFF_FFF2);
    check_output("back-to-back remainder", remainder, 32'hFFFF_FFFE);
    next_cycle();

    $display("[TB] reset during a division");
    apply_stimulus(1'b0, 32'd1000, 32'd3);
    repeat (14) next_cycle();
    check_output("pre-abort busy", busy, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_output("abort busy", busy, 0);
    check_output("abort done", done, 0);
    check_output("abort quotient", quotient, 0);
    check_output("abort remainder", remainder, 0);
    check_output("abort dbz", div_by_zero, 0);
    done_seen = 0;
    repeat (2 * LAT) begin
      next_cycle();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check_output("abort no done", done_seen, 0);

    run_div("divu after abort", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
